f1_reaction_timer: RTL and testbench
====================================

F1_REACTION_TIMER -- requirements
Module: f1_reaction_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the reaction-time counter, in ticks.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port tick, input, 1: one-cycle timebase pulse (1 ms nominal).
REQ-005 SHALL have port lights, input, [8:1]: start-light pattern from the light sequencer, synchronous to clk.
REQ-006 SHALL have port btn, input, 1: debounced, synchronous player button (level).
REQ-007 SHALL have port clr, input, 1: synchronous clear of result and flags.
REQ-008 SHALL have port time_out, output, [CNT_W-1:0]: last captured reaction time, in ticks.
REQ-009 SHALL have port valid, output, 1: time_out holds a fresh result.
REQ-010 SHALL have port jump_start, output, 1: button pressed before lights out.
REQ-011 SHALL have port err, output, 1: illegal light pattern detected.
REQ-012 SHALL have port busy, output, 1: high while in ARMED, READY or TIMING.
REQ-013 SHALL have port best_time, output, [CNT_W-1:0]: best (minimum) result; see Configuration.
REQ-014 SHALL have port new_best, output, 1: one-cycle pulse when best_time improves.

Function
REQ-015 SHALL detect a press as btn=1 while the registered btn from the previous cycle is 0; a held button SHALL produce only one press.
REQ-016 SHALL treat lights as legal only when it is a thermometer code: 8'h00, 01, 03, 07, 0F, 1F, 3F, 7F or FF.
REQ-017 SHALL implement the states IDLE, ARMED, READY, TIMING, DONE, JUMP and ERROR.
REQ-018 SHALL, in IDLE, go to ARMED when lights==8'h01, and otherwise stay in IDLE, ignoring presses and any other pattern.
REQ-019 SHALL, in ARMED:
- go to JUMP on a press (highest priority);
- otherwise go to ERROR on an illegal pattern or lights==8'h00;
- otherwise go to READY on lights==8'hFF;
- otherwise stay in ARMED.
REQ-020 SHALL, in READY:
- go to JUMP on a press (highest priority);
- otherwise go to TIMING on lights==8'h00, loading the counter with 0;
- otherwise stay in READY while lights==8'hFF;
- otherwise go to ERROR.
REQ-021 SHALL, in TIMING, increment the counter by 1 on each tick and saturate it at 2^CNT_W-1.
REQ-022 SHALL, in TIMING on a press, load time_out with the current counter value, excluding any tick in the same cycle, and go to DONE.
REQ-023 SHALL, in TIMING with no press and lights!=8'h00, go to ERROR.
REQ-024 SHALL set valid=1 in DONE, jump_start=1 in JUMP and err=1 in ERROR; each SHALL stay set until clr.
REQ-025 SHALL, on clr, go to IDLE from any state and clear valid, jump_start and err on the next edge; time_out SHALL hold its value.
REQ-026 SHALL give clr priority over every transition listed above.
REQ-027 SHALL leave time_out unchanged in every state other than the TIMING press case.

Reset
REQ-028 SHALL, while rst=1, force state=IDLE, counter=0, time_out=0, valid=0, jump_start=0, err=0, busy=0, new_best=0 and registered btn=0.
REQ-029 SHALL, while rst=1, force best_time to all ones.
REQ-030 SHALL, on rst mid-TIMING, discard the measurement with no capture and no flag.

Configuration
REQ-031 SHALL, with macro RT_BEST_TRACK_EN defined, set best_time to time_out's new value on entry to DONE when that value is strictly less than best_time, and pulse new_best for one cycle.
REQ-032 SHALL, with macro RT_BEST_TRACK_EN defined, keep best_time unchanged by clr.
REQ-033 SHALL, without RT_BEST_TRACK_EN, tie best_time to all ones and new_best to 0, with no tracking logic.

Verification
REQ-034 SHALL cover a normal run: lights 01,03,...,FF then 00, 250 ticks, then press -> time_out=250, valid=1, busy=0.
REQ-035 SHALL cover a jump start: press while lights==8'h0F -> jump_start=1, valid=0, time_out unchanged; clr -> IDLE, jump_start=0.
REQ-036 SHALL cover an illegal pattern: lights==8'h05 in ARMED -> err=1; a later lights==8'h01 stays in ERROR until clr.
REQ-037 SHALL cover saturation: CNT_W=4, 20 ticks in TIMING, then press -> time_out=15.
REQ-038 SHALL cover a simultaneous tick and press with counter=7 -> time_out=7, plus rst asserted mid-TIMING -> all outputs 0, state IDLE.
REQ-039 SHALL cover, with RT_BEST_TRACK_EN, results 300 then 200 then 250 -> best_time 300, then 200, then 200; new_best pulses twice.

Source files
------------

// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: F1 start-light reaction timer; optional best-time tracking under RT_BEST_TRACK_EN
module f1_reaction_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [8:1]       lights,
  input  logic             btn,
  input  logic             clr,
  output logic [CNT_W-1:0] time_out,
  output logic             valid,
  output logic             jump_start,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] best_time,
  output logic             new_best
);
  typedef enum logic [2:0] {IDLE, ARMED, READY, TIMING, DONE, JUMP, ERROR} state_t;
  state_t state, state_nxt;
  logic btn_q, press, legal, dark, full, load, capture;
  logic [CNT_W-1:0] cnt;
  assign press = btn & ~btn_q;
  assign dark  = lights == 8'h00;
  assign full  = lights == 8'hFF;
  // a thermometer code has no zero below its highest one, so x & (x+1) is zero
  assign legal = (lights & (lights + 8'h01)) == 8'h00;
  // state and button history; reset discards any measurement in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      btn_q <= 1'b0;
    end else begin
      state <= state_nxt;
      btn_q <= btn;
    end
  // next-state decode; clr overrides everything, result states latch until clr
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    if (clr) state_nxt = IDLE;
    else case (state)
      IDLE:    state_nxt = lights == 8'h01 ? ARMED : IDLE;
      ARMED:   state_nxt = press ? JUMP : (!legal || dark) ? ERROR : full ? READY : ARMED;
      READY: begin
        state_nxt = press ? JUMP : dark ? TIMING : full ? READY : ERROR;
        load      = !press && dark;
      end
      TIMING: begin
        state_nxt = press ? DONE : dark ? TIMING : ERROR;
        capture   = press;
      end
      default: state_nxt = state;
    endcase
  end
  // reaction counter: cleared at lights out, saturating tick count, captured on press
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt      <= '0;
      time_out <= '0;
    end else begin
      if (load) cnt <= '0;
      else if (state == TIMING && tick && cnt != '1) cnt <= cnt + 1'b1;
      if (capture) time_out <= cnt;
    end
  assign valid      = state == DONE;
  assign jump_start = state == JUMP;
  assign err        = state == ERROR;
  assign busy       = state == ARMED || state == READY || state == TIMING;
`ifdef RT_BEST_TRACK_EN
  // best result survives clr; only a strictly faster capture replaces it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      best_time <= '1;
      new_best  <= 1'b0;
    end else begin
      new_best <= capture && cnt < best_time;
      if (capture && cnt < best_time) best_time <= cnt;
    end
`else
  assign best_time = '1;
  assign new_best  = 1'b0;
`endif
endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb_f1_reaction_timer: scoreboard bench for f1_reaction_timer, 16-bit and 4-bit counters in parallel
module tb_f1_reaction_timer;
  typedef struct packed {
    logic [15:0] t16;
    logic [3:0]  t4;
    logic        nb;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, btn = 1'b0, clr = 1'b0;
  logic [8:1] lights = 8'h00;
  logic [15:0] time16, best16;
  logic [3:0] time4, best4;
  logic valid16, jump16, err16, busy16, nb16;
  logic valid4, jump4, err4, busy4, nb4;
  exp_t sb[$];
  int checks = 0, errors = 0, nb_cnt = 0, mbest = 65535;
  f1_reaction_timer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .tick(tick), .lights(lights), .btn(btn), .clr(clr),
    .time_out(time16), .valid(valid16), .jump_start(jump16), .err(err16), .busy(busy16),
    .best_time(best16), .new_best(nb16)
  );
  f1_reaction_timer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .lights(lights), .btn(btn), .clr(clr),
    .time_out(time4), .valid(valid4), .jump_start(jump4), .err(err4), .busy(busy4),
    .best_time(best4), .new_best(nb4)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (nb16 === 1'b1) nb_cnt++;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask
  task automatic arm_to_timing();
    logic [7:0] seq [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
    for (int i = 0; i < 9; i++) begin
      lights = seq[i];
      step();
    end
  endtask
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask
  task automatic do_press(input string name, input int n, input bit with_tick);
    exp_t e;
    e.t16 = 16'(n);
    e.t4  = n > 15 ? 4'hF : 4'(n);
`ifdef RT_BEST_TRACK_EN
    e.nb = n < mbest;
    if (n < mbest) mbest = n;
`else
    e.nb = 1'b0;
`endif
    sb.push_back(e);
    tick = with_tick;
    btn  = 1'b1;
    step();
    tick = 1'b0;
    btn  = 1'b0;
    for (int i = 0; i < 8 && valid16 !== 1'b1; i++) step();
    e = sb.pop_front();
    checks++;
    if (valid16 !== 1'b1) begin errors++; $display("FAIL %s valid: got %b want 1", name, valid16); end
    checks++;
    if (time16 !== e.t16) begin errors++; $display("FAIL %s time_out: got %0d want %0d", name, time16, e.t16); end
    checks++;
    if (time4 !== e.t4) begin errors++; $display("FAIL %s time_out(w4): got %0d want %0d", name, time4, e.t4); end
    checks++;
    if (nb16 !== e.nb) begin errors++; $display("FAIL %s new_best: got %b want %b", name, nb16, e.nb); end
    checks++;
    if (busy16 !== 1'b0 || valid4 !== 1'b1) begin errors++; $display("FAIL %s busy/valid4: got %b/%b want 0/1", name, busy16, valid4); end
  endtask
  task automatic test_reset();
    step();
    step();
    checks++;
    if ({time16, valid16, jump16, err16, busy16, nb16} !== 21'd0) begin
      errors++; $display("FAIL reset outputs: got %h/%b%b%b%b%b want 0", time16, valid16, jump16, err16, busy16, nb16);
    end
    checks++;
    if (best16 !== 16'hFFFF || best4 !== 4'hF) begin errors++; $display("FAIL reset best_time: got %h/%h want ffff/f", best16, best4); end
    checks++;
    if ({time4, valid4, jump4, err4, busy4, nb4} !== 9'd0) begin errors++; $display("FAIL reset outputs(w4): got nonzero want 0"); end
    rst = 1'b0;
    step();
  endtask
  task automatic test_normal();
    arm_to_timing();
    checks++;
    if (busy16 !== 1'b1) begin errors++; $display("FAIL normal busy: got %b want 1", busy16); end
    tick_n(250);
    do_press("normal", 250, 1'b0);
    do_clr();
    checks++;
    if (valid16 !== 1'b0 || time16 !== 16'd250) begin errors++; $display("FAIL normal clr: got valid %b time %0d want 0 250", valid16, time16); end
  endtask
  task automatic test_saturation();
    arm_to_timing();
    tick_n(20);
    do_press("saturate", 20, 1'b0);
    do_clr();
  endtask
  task automatic test_tick_press();
    arm_to_timing();
    tick_n(7);
    do_press("tick_press", 7, 1'b1);
    do_clr();
  endtask
  task automatic test_jump();
    btn = 1'b1;
    step();
    lights = 8'h01;
    step();
    lights = 8'h03;
    step();
    checks++;
    if (busy16 !== 1'b1 || jump16 !== 1'b0) begin errors++; $display("FAIL held_btn: got busy %b jump %b want 1 0", busy16, jump16); end
    btn = 1'b0;
    lights = 8'h07;
    step();
    lights = 8'h0F;
    btn = 1'b1;
    step();
    btn = 1'b0;
    checks++;
    if (jump16 !== 1'b1 || valid16 !== 1'b0 || busy16 !== 1'b0) begin errors++; $display("FAIL jump flags: got j%b v%b b%b want 1 0 0", jump16, valid16, busy16); end
    checks++;
    if (time16 !== 16'd7) begin errors++; $display("FAIL jump time_out: got %0d want 7", time16); end
    lights = 8'hFF;
    step();
    checks++;
    if (jump16 !== 1'b1) begin errors++; $display("FAIL jump hold: got %b want 1", jump16); end
    do_clr();
    checks++;
    if (jump16 !== 1'b0 || busy16 !== 1'b0) begin errors++; $display("FAIL jump clr: got j%b b%b want 0 0", jump16, busy16); end
    lights = 8'h00;
    step();
  endtask
  task automatic test_illegal();
    lights = 8'h01;
    step();
    lights = 8'h05;
    step();
    checks++;
    if (err16 !== 1'b1 || busy16 !== 1'b0) begin errors++; $display("FAIL illegal err: got e%b b%b want 1 0", err16, busy16); end
    lights = 8'h01;
    step();
    step();
    checks++;
    if (err16 !== 1'b1 || busy16 !== 1'b0) begin errors++; $display("FAIL illegal sticky: got e%b b%b want 1 0", err16, busy16); end
    do_clr();
    checks++;
    if (err16 !== 1'b0) begin errors++; $display("FAIL illegal clr: got %b want 0", err16); end
    step();
    checks++;
    if (busy16 !== 1'b1) begin errors++; $display("FAIL rearm: got busy %b want 1", busy16); end
    lights = 8'h00;
    step();
    checks++;
    if (err16 !== 1'b1) begin errors++; $display("FAIL armed dark: got err %b want 1", err16); end
    do_clr();
  endtask
  task automatic test_rst_mid();
    arm_to_timing();
    tick_n(5);
    rst = 1'b1;
    #1;
    checks++;
    if ({time16, valid16, jump16, err16, busy16, nb16} !== 21'd0) begin errors++; $display("FAIL rst_mid outputs: got %h/%b%b%b%b%b want 0", time16, valid16, jump16, err16, busy16, nb16); end
    step();
    rst = 1'b0;
    btn = 1'b1;
    step();
    btn = 1'b0;
    step();
    checks++;
    if (valid16 !== 1'b0 || busy16 !== 1'b0 || time16 !== 16'd0) begin errors++; $display("FAIL rst_mid idle: got v%b b%b t%0d want 0 0 0", valid16, busy16, time16); end
  endtask
  task automatic test_best();
    int runs [3] = '{300, 200, 250};
    logic [15:0] eb;
    mbest = 65535;
    nb_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      arm_to_timing();
      tick_n(runs[i]);
      do_press("best", runs[i], 1'b0);
`ifdef RT_BEST_TRACK_EN
      eb = 16'(mbest);
`else
      eb = 16'hFFFF;
`endif
      checks++;
      if (best16 !== eb) begin errors++; $display("FAIL best run%0d: got %0d want %0d", i, best16, eb); end
      do_clr();
      step();
      checks++;
      if (best16 !== eb) begin errors++; $display("FAIL best clr%0d: got %0d want %0d", i, best16, eb); end
    end
    checks++;
`ifdef RT_BEST_TRACK_EN
    if (nb_cnt !== 2) begin errors++; $display("FAIL new_best pulses: got %0d want 2", nb_cnt); end
`else
    if (nb_cnt !== 0) begin errors++; $display("FAIL new_best pulses: got %0d want 0", nb_cnt); end
`endif
  endtask
  initial begin
    test_reset();
    test_normal();
    test_saturation();
    test_tick_press();
    test_jump();
    test_illegal();
    test_rst_mid();
    test_best();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
